// File: rtl/conv_adder_tree_pipe_if.sv
// conv_adder_tree_pipe_if: window stream into the adder tree, saturated result stream out
interface conv_adder_tree_pipe_if #(
    parameter int BIT_WIDTH  = 32,
    parameter int N_IN       = 25,
    parameter int BIAS_WIDTH = 8
);
    logic                      in_valid;
    logic [BIT_WIDTH*N_IN-1:0] in_data;
    logic [BIAS_WIDTH-1:0]     bias;
    logic                      relu_en;
    logic                      clear;
    logic                      out_valid;
    logic [BIT_WIDTH-1:0]      out_data;
    logic                      busy;
    modport master (output in_valid, in_data, bias, relu_en, clear, input out_valid, out_data, busy);
    modport slave  (input in_valid, in_data, bias, relu_en, clear, output out_valid, out_data, busy);
endinterface

// File: rtl/conv_adder_tree_pipe.sv
// conv_adder_tree_pipe: registered adder tree with per-channel accumulation, bias, ReLU and saturation
module conv_adder_tree_pipe #(
    parameter int BIT_WIDTH  = 32,
    parameter int N_IN       = 25,
    parameter int BIAS_WIDTH = 8,
    parameter int NUM_CH     = 1
) (
    input logic                  clk,
    input logic                  rst,
    conv_adder_tree_pipe_if.slave bus
);
    localparam int S  = $clog2(N_IN);
    localparam int W  = BIT_WIDTH + $clog2(N_IN * NUM_CH) + 1;
    localparam int RW = W + 1;
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic signed [RW-1:0] sat_max = {{(RW-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] sat_min = {{(RW-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    function automatic int lvl_cnt(input int l);
        return (N_IN + (1 << l) - 1) >> l;
    endfunction

    for (genvar l = 0; l <= S; l++) begin : g_lvl
        localparam int C = lvl_cnt(l);
        logic signed [W-1:0] val [C];
        if (l == 0) begin : g_in
            for (genvar i = 0; i < C; i++) begin : g_i
                assign val[i] = W'($signed(bus.in_data[BIT_WIDTH*i +: BIT_WIDTH]));
            end
        end else begin : g_reg
            logic signed [W-1:0] val_d [C];
            logic signed [W-1:0] val_q [C];
            for (genvar i = 0; i < C; i++) begin : g_i
                if (2*i+1 < lvl_cnt(l-1)) begin : g_add
                    assign val_d[i] = g_lvl[l-1].val[2*i] + g_lvl[l-1].val[2*i+1];
                end else begin : g_pass
                    assign val_d[i] = g_lvl[l-1].val[2*i];
                end
            end
            always_ff @(posedge clk) val_q <= val_d;
            assign val = val_q;
        end
    end

    logic [S:1]                  vld_d, vld_q;
    logic [S:1][BIAS_WIDTH-1:0]  bias_d, bias_q;
    logic [CW-1:0]               ch_cnt_d, ch_cnt_q;
    logic signed [W-1:0]         acc_d, acc_q, res;
    logic signed [RW-1:0]        r, rr;
    logic                        first, last;
    logic                        out_valid_d, out_valid_q, busy_d, busy_q;
    logic [BIT_WIDTH-1:0]        out_data_d, out_data_q;

    always_comb begin
        res         = g_lvl[S].val[0];
        first       = ch_cnt_q == '0;
        last        = ch_cnt_q == CW'(NUM_CH - 1);
        vld_d       = bus.clear ? '0 : S'({vld_q, bus.in_valid});
        bias_d      = (S*BIAS_WIDTH)'({bias_q, bus.bias});
        acc_d       = bus.clear ? '0 : vld_q[S] ? (first ? res : acc_q + res) : acc_q;
        ch_cnt_d    = bus.clear ? '0 : vld_q[S] ? (last ? '0 : ch_cnt_q + 1'b1) : ch_cnt_q;
        r           = RW'(first ? res : acc_q + res) + RW'($signed(bias_q[S]));
        rr          = (bus.relu_en && r < 0) ? '0 : r;
        out_valid_d = !bus.clear && vld_q[S] && last;
        out_data_d  = !out_valid_d ? out_data_q :
                      rr > sat_max ? sat_max[BIT_WIDTH-1:0] :
                      rr < sat_min ? sat_min[BIT_WIDTH-1:0] : rr[BIT_WIDTH-1:0];
        busy_d      = !bus.clear && (|vld_q || !first);
    end

    always_ff @(posedge clk) bias_q <= bias_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            ch_cnt_q    <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            ch_cnt_q    <= ch_cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_conv_adder_tree_pipe.sv
// tb_conv_adder_tree_pipe: three channel-count variants checked against a window-level model
module tb_conv_adder_tree_pipe;
    localparam int BW = 32, NI = 25, BIW = 8, S = 5;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic               v = 1'b0, clr = 1'b0, relu = 1'b0;
    logic [BIW-1:0]     b = '0;
    logic [BW*NI-1:0]   dat = '0;
    logic               ov [3];
    logic [BW-1:0]      od [3];
    logic               bz [3];

    conv_adder_tree_pipe_if #(.BIT_WIDTH(BW), .N_IN(NI), .BIAS_WIDTH(BIW)) bus [3] ();

    for (genvar j = 0; j < 3; j++) begin : g_dut
        assign bus[j].in_valid = v;
        assign bus[j].in_data  = dat;
        assign bus[j].bias     = b;
        assign bus[j].relu_en  = relu;
        assign bus[j].clear    = clr;
        assign ov[j] = bus[j].out_valid;
        assign od[j] = bus[j].out_data;
        assign bz[j] = bus[j].busy;
        conv_adder_tree_pipe #(.BIT_WIDTH(BW), .N_IN(NI), .BIAS_WIDTH(BIW), .NUM_CH(j+1)) u_dut (
            .clk(clk), .rst(rst), .bus(bus[j]));
    end

    int     passed = 0, total = 0, cyc = 0;
    int     cnt_m [3];
    longint acc_m [3];
    bit     pv [3][8];
    longint pd [3][8];
    longint ed [3];
    int     pulses [3];
    longint cur_sum;

    typedef struct { int prod; int bias; bit re; int exp; } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input int j, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s dut%0d cyc %0d: got %0d want %0d", nm, j, cyc, act, exp);
    endtask

    function automatic longint model_out(input longint s, input longint bb, input bit re);
        longint x = s + bb;
        if (re && x < 0) x = 0;
        if (x > 64'sd2147483647) x = 64'sd2147483647;
        if (x < -64'sd2147483648) x = -64'sd2147483648;
        return x;
    endfunction

    task automatic step();
        for (int j = 0; j < 3; j++) begin
            if (rst) begin
                cnt_m[j] = 0; acc_m[j] = 0; ed[j] = 0;
                for (int k = 0; k < 8; k++) pv[j][k] = 0;
            end else if (clr) begin
                cnt_m[j] = 0; acc_m[j] = 0;
                for (int k = 0; k < 8; k++) pv[j][k] = 0;
            end else if (v) begin
                acc_m[j] += cur_sum;
                cnt_m[j]++;
                if (cnt_m[j] == j + 1) begin
                    pv[j][(cyc+S+1)%8] = 1;
                    pd[j][(cyc+S+1)%8] = model_out(acc_m[j], longint'($signed(b)), relu);
                    cnt_m[j] = 0; acc_m[j] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int j = 0; j < 3; j++) begin
            if (pv[j][cyc%8]) ed[j] = pd[j][cyc%8];
            chk("out_valid", j, longint'(ov[j]), longint'(pv[j][cyc%8]));
            chk("out_data", j, longint'($signed(od[j])), ed[j]);
            if (ov[j]) pulses[j]++;
            pv[j][cyc%8] = 0;
        end
    endtask

    task automatic win_all(input int p);
        for (int k = 0; k < NI; k++) dat[BW*k +: BW] = p;
        cur_sum = NI * longint'(p);
        v = 1'b1;
    endtask

    task automatic win_rand();
        int p;
        cur_sum = 0;
        for (int k = 0; k < NI; k++) begin
            p = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
            dat[BW*k +: BW] = p;
            cur_sum += longint'(p);
        end
        b = BIW'($urandom_range(0, 255));
        v = 1'b1;
    endtask

    task automatic idle(input int n);
        v = 1'b0;
        repeat (n) step();
    endtask

    task automatic abort_seq(input bit use_rst, input string nm);
        int p0;
        p0 = pulses[2];
        win_all(9); step(); step();
        win_all(50);
        if (use_rst) rst = 1'b1; else clr = 1'b1;
        step();
        rst = 1'b0; clr = 1'b0; b = '0;
        win_all(1); step(); step(); step();
        idle(7);
        chk({nm, "_pulses"}, 2, pulses[2] - p0, 1);
        chk({nm, "_data"}, 2, longint'($signed(od[2])), 75);
    endtask

    initial begin
        tbl[0] = '{1, 3, 1'b0, 28};
        tbl[1] = '{32'h7FFFFFFF, 127, 1'b0, 32'h7FFFFFFF};
        tbl[2] = '{32'h80000000, -128, 1'b0, 32'h80000000};
        tbl[3] = '{-1, 0, 1'b1, 0};
        tbl[4] = '{-1, 0, 1'b0, -25};
        tbl[5] = '{7, -100, 1'b1, 75};
        tbl[6] = '{-3, 50, 1'b1, 0};
        for (int j = 0; j < 3; j++) pulses[j] = 0;

        rst = 1'b1;
        step(); step();
        for (int j = 0; j < 3; j++) chk("reset_busy", j, longint'(bz[j]), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            relu = tbl[i].re;
            b = tbl[i].bias[BIW-1:0];
            win_all(tbl[i].prod);
            step();
            idle(5);
            chk("tbl_valid", 0, longint'(ov[0]), 1);
            chk("tbl_data", 0, longint'($signed(od[0])), longint'(tbl[i].exp));
            idle(1);
        end
        relu = 1'b0;

        rst = 1'b1; step(); rst = 1'b0;
        b = 8'd77;
        win_all(2); step();
        win_all(-1); step();
        b = -8'sd5;
        win_all(4); step();
        v = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) chk("grp_busy", 2, longint'(bz[2]), 1);
            chk("grp_valid", 2, longint'(ov[2]), longint'(k == 5));
        end
        chk("grp_data", 2, longint'($signed(od[2])), 120);

        rst = 1'b1; step(); rst = 1'b0;
        abort_seq(1'b0, "clear");
        abort_seq(1'b1, "rst");

        rst = 1'b1; step(); rst = 1'b0;
        win_rand(); step();
        idle(3);
        win_rand(); step();
        for (int i = 0; i < 100; i++) begin
            win_rand(); step();
        end
        idle(5);
        chk("last_valid", 1, longint'(ov[1]), 1);
        chk("last_busy", 1, longint'(bz[1]), 1);
        idle(1);
        for (int j = 0; j < 3; j++) chk("busy_fall", j, longint'(bz[j]), 0);

        relu = 1'b1;
        for (int i = 0; i < 30; i++) begin
            win_rand(); step();
        end
        idle(7);
        relu = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
